// File: rtl/seg_scan_sched.sv
// seg_scan_sched: 6-digit common-anode scan scheduler with PWM and frame buffer.
// Optional lamp test input is enabled by defining SEG_LAMP_TEST_EN.
module seg_scan_sched #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  digit_en,
  input  logic [3:0]  bright,
  input  logic [47:0] seg_frame,
  input  logic        upd_valid,
`ifdef SEG_LAMP_TEST_EN
  input  logic        lamp_test,
`endif
  output logic        upd_ready,
  output logic [5:0]  seg_sel,
  output logic [7:0]  seg_data,
  output logic        frame_start
);

  localparam int CW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } state_t;

  state_t         state, st_n;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  diff;
  logic [2:0]     cur, cur_n, nxt, lo;
  logic [47:0]    active, pending;
  logic           pend_full, pf_n;
  logic           slot_end, fb, found, lit, xfer, lamp;
  logic [5:0]     en_mask, sel_d;
  logic [7:0]     data_d;
  logic [3:0]     pwm;

`ifdef SEG_LAMP_TEST_EN
  assign lamp = lamp_test;
`else
  assign lamp = 1'b0;
`endif

  assign en_mask  = lamp ? 6'h3F : digit_en;
  assign slot_end = (cnt == CW'(SCAN_DIV - 1));
  assign diff     = cnt - CW'(BLANK_CYCLES);
  assign pwm      = diff[3:0];
  assign xfer     = upd_valid && upd_ready;

  function automatic logic [2:0] lowest(input logic [5:0] m);
    lowest = '0;
    for (int i = 5; i >= 0; i--)
      if (m[i]) lowest = 3'(i);
  endfunction

  // Search upward from cur+1 (mod 6) for the next enabled digit
  always_comb begin
    logic [2:0] idx;
    nxt   = cur;
    found = 1'b0;
    lo    = lowest(en_mask);
    for (int k = 1; k <= 6; k++) begin
      idx = 3'((int'(cur) + k) % 6);
      if (!found && en_mask[idx]) begin
        found = 1'b1;
        nxt   = idx;
      end
    end
  end

  // Slot sequencing: next state, next digit and frame boundary flag
  always_comb begin
    st_n  = state;
    cur_n = cur;
    fb    = 1'b0;
    case (state)
      IDLE: begin
        if (slot_end && en_mask != 6'h00) begin
          st_n  = BLANK;
          cur_n = lo;
          fb    = 1'b1;
        end
      end
      BLANK: begin
        if (cnt == CW'(BLANK_CYCLES - 1))
          st_n = DRIVE;
      end
      DRIVE: begin
        if (slot_end) begin
          if (en_mask == 6'h00) begin
            st_n = IDLE;
          end else begin
            st_n  = BLANK;
            cur_n = nxt;
            fb    = (nxt <= cur);
          end
        end
      end
      default: st_n = BLANK;
    endcase
  end

  // Pin decode before the output register
  always_comb begin
    lit    = (state == DRIVE) && (pwm < bright);
    sel_d  = 6'h3F;
    data_d = 8'hFF;
    if (lit) begin
      sel_d      = 6'h3F;
      sel_d[cur] = 1'b0;
      data_d     = lamp ? 8'h00 : active[{cur, 3'b000} +: 8];
    end
  end

  // Pending buffer occupancy after this cycle
  always_comb begin
    pf_n = pend_full;
    if (fb && pend_full) pf_n = 1'b0;
    if (xfer)            pf_n = 1'b1;
  end

  // State, counter, frame buffers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      state       <= BLANK;
      cur         <= lo;
      active      <= '1;
      pending     <= '1;
      pend_full   <= 1'b0;
      upd_ready   <= 1'b1;
      seg_sel     <= 6'h3F;
      seg_data    <= 8'hFF;
      frame_start <= 1'b0;
    end else begin
      cnt         <= slot_end ? '0 : cnt + CW'(1);
      state       <= st_n;
      cur         <= cur_n;
      frame_start <= fb;
      seg_sel     <= sel_d;
      seg_data    <= data_d;
      if (fb && pend_full) active <= pending;
      if (xfer)            pending <= seg_frame;
      pend_full   <= pf_n;
      upd_ready   <= !pf_n;
    end
  end

endmodule

// File: tb/tb_seg_scan_sched.sv
// tb_seg_scan_sched: slot-level scoreboard bench for seg_scan_sched.
// Runs with SCAN_DIV=32, BLANK_CYCLES=4; SEG_LAMP_TEST_EN adds a lamp phase.
module tb_seg_scan_sched;

  localparam int SD = 32;
  localparam int BC = 4;
  localparam logic [47:0] FA = 48'hA5A4A3A2A1C0;
  localparam logic [47:0] FB = 48'hB5B4B3B2B1B0;
  localparam logic [47:0] FC = 48'h5A4B3C2D1E0F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  digit_en = 6'h3F;
  logic [3:0]  bright = 4'd15;
  logic [47:0] seg_frame = '0;
  logic        upd_valid = 1'b0;
`ifdef SEG_LAMP_TEST_EN
  logic        lamp_test = 1'b0;
`endif
  logic        upd_ready;
  logic [5:0]  seg_sel;
  logic [7:0]  seg_data;
  logic        frame_start;

  seg_scan_sched #(
    .SCAN_DIV(SD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .digit_en(digit_en),
    .bright(bright),
    .seg_frame(seg_frame),
    .upd_valid(upd_valid),
`ifdef SEG_LAMP_TEST_EN
    .lamp_test(lamp_test),
`endif
    .upd_ready(upd_ready),
    .seg_sel(seg_sel),
    .seg_data(seg_data),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         slot;
    logic [5:0] sel;
    logic [7:0] data;
    int         low;
    bit         fs;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [5:0] sel_of(input int d);
    case (d)
      0: return 6'h3E;
      1: return 6'h3D;
      2: return 6'h3B;
      3: return 6'h37;
      4: return 6'h2F;
      5: return 6'h1F;
      default: return 6'h3F;
    endcase
  endfunction

  function automatic logic [7:0] byte_of(input logic [47:0] f,
                                         input int k);
    return f[k*8 +: 8];
  endfunction

  // 28 drive cycles: pwm runs 0..15 then 0..11
  function automatic int exp_low(input int b);
    return (b > 16 ? 16 : b) + (b > 12 ? 12 : b);
  endfunction

  task automatic push(input int sl, input logic [5:0] se,
                      input logic [7:0] d, input int lo, input bit f);
    exp_t e;
    e.slot = sl;
    e.sel  = se;
    e.data = d;
    e.low  = lo;
    e.fs   = f;
    q.push_back(e);
  endtask

  // Slot-position reference: counter restarts on reset
  int   tcnt = 0;
  logic rst_q = 1'b1;
  always @(posedge clk) begin
    rst_q <= rst;
    if (rst) tcnt <= 0;
    else     tcnt <= (tcnt == SD - 1) ? 0 : tcnt + 1;
  end

  // Monitor: gathers one record per slot, compares at slot end
  int         slot_no = 0;
  logic [5:0] r_sel = 6'h3F;
  logic [7:0] r_data = 8'hFF;
  int         r_low = 0;
  bit         r_fs = 1'b0;
  bit         r_bad = 1'b0;

  task automatic absorb();
    if (seg_sel != 6'h3F) begin
      if ($countones(~seg_sel) != 1) r_bad = 1'b1;
      if (r_sel != 6'h3F && r_sel != seg_sel) r_bad = 1'b1;
      if (r_sel != 6'h3F && r_data != seg_data) r_bad = 1'b1;
      r_sel  = seg_sel;
      r_data = seg_data;
      r_low++;
    end else if (seg_data != 8'hFF) begin
      r_bad = 1'b1;
    end
  endtask

  task automatic clear_rec();
    r_sel  = 6'h3F;
    r_data = 8'hFF;
    r_low  = 0;
    r_bad  = 1'b0;
    r_fs   = frame_start;
  endtask

  task automatic finalize();
    exp_t e;
    while (q.size() > 0 && q[0].slot < slot_no) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_slot: got none expected slot %0d", e.slot);
    end
    if (q.size() > 0 && q[0].slot == slot_no) begin
      e = q.pop_front();
      chk($sformatf("sel_s%0d", slot_no), r_sel, e.sel);
      chk($sformatf("low_s%0d", slot_no), r_low, e.low);
      chk($sformatf("fs_s%0d", slot_no), r_fs, e.fs);
      chk($sformatf("clean_s%0d", slot_no), r_bad, 0);
      if (e.sel != 6'h3F)
        chk($sformatf("data_s%0d", slot_no), r_data, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (rst_q) begin
      clear_rec();
    end else if (tcnt == 0) begin
      absorb();
      finalize();
      slot_no++;
      clear_rec();
    end else begin
      if (frame_start) r_bad = 1'b1;
      absorb();
    end
  end

  task automatic next_slot_to(input int n);
    int g = 0;
    while (!(slot_no == n && tcnt == 1)) begin
      @(posedge clk);
      #2;
      g++;
      if (g > 4000) begin
        checks++;
        errors++;
        $display("FAIL slot_wait: got slot %0d expected %0d", slot_no, n);
        break;
      end
    end
  endtask

  task automatic send(input logic [47:0] f);
    int g = 0;
    upd_valid = 1'b1;
    seg_frame = f;
    @(negedge clk);
    while (!upd_ready && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (!upd_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got ready 0 expected 1");
    end
    @(posedge clk);
    #1 upd_valid = 1'b0;
  endtask

  initial begin
    int s;
    int s2;
    int fin;
    int g;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_sel", seg_sel, 6'h3F);
    chk("rst_data", seg_data, 8'hFF);
    chk("rst_ready", upd_ready, 1'b1);
    chk("rst_fs", frame_start, 1'b0);

    s = slot_no;
    for (int k = 0; k < 12; k++)
      push(s + k, sel_of(k % 6), 8'hFF, exp_low(15), k == 6);

    next_slot_to(s + 11);
    digit_en = 6'b010010;
    push(s + 12, sel_of(1), 8'hFF, 27, 1);
    push(s + 13, sel_of(4), 8'hFF, 27, 0);
    push(s + 14, sel_of(1), 8'hFF, 27, 1);
    push(s + 15, sel_of(4), 8'hFF, 27, 0);

    next_slot_to(s + 15);
    digit_en = 6'h3F;
    send(FA);
    chk("ready_low_after_a", upd_ready, 1'b0);
    push(s + 16, sel_of(5), 8'hFF, 27, 0);
    for (int k = 0; k < 6; k++)
      push(s + 17 + k, sel_of(k), byte_of(FA, k), 27, k == 0);
    for (int k = 0; k < 5; k++)
      push(s + 23 + k, sel_of(k), byte_of(FB, k), 27, k == 0);
    send(FB);
    chk("b_accept_slot", slot_no, s + 17);
    chk("b_accept_cnt", tcnt, 1);
    chk("ready_low_after_b", upd_ready, 1'b0);

    next_slot_to(s + 28);
    bright = 4'd0;
    for (int k = 0; k < 6; k++)
      push(s + 28 + k, 6'h3F, 8'hFF, 0, k == 1);

    next_slot_to(s + 34);
    bright = 4'd8;
    push(s + 34, sel_of(5), byte_of(FB, 5), 16, 0);
    for (int k = 0; k < 6; k++)
      push(s + 35 + k, sel_of(k), byte_of(FB, k), 16, k == 0);

    next_slot_to(s + 40);
    digit_en = 6'h00;
    push(s + 41, 6'h3F, 8'hFF, 0, 0);
    push(s + 42, 6'h3F, 8'hFF, 0, 0);
    push(s + 43, sel_of(2), byte_of(FB, 2), 16, 1);
    push(s + 44, sel_of(2), byte_of(FB, 2), 16, 1);

    next_slot_to(s + 42);
    digit_en = 6'h04;

    next_slot_to(s + 44);
    digit_en = 6'h3F;
    send(FC);

    next_slot_to(s + 45);
    g = 0;
    while (tcnt != 10 && g < 100) begin
      @(posedge clk);
      #2;
      g++;
    end
    chk("pend_before_rst", upd_ready, 1'b0);
    chk("d3_before_rst", seg_sel, 6'h37);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_sel", seg_sel, 6'h3F);
    chk("mid_rst_data", seg_data, 8'hFF);
    chk("mid_rst_ready", upd_ready, 1'b1);
    chk("mid_rst_fs", frame_start, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    s2 = slot_no;
    for (int k = 0; k < 6; k++)
      push(s2 + k, sel_of(k), 8'hFF, 16, 0);
    push(s2 + 6, sel_of(0), 8'hFF, 16, 1);
    fin = s2 + 7;

`ifdef SEG_LAMP_TEST_EN
    next_slot_to(s2 + 7);
    lamp_test = 1'b1;
    for (int k = 0; k < 6; k++)
      push(s2 + 8 + k, sel_of((k + 2) % 6), 8'h00, 16, k == 4);
    next_slot_to(s2 + 14);
    lamp_test = 1'b0;
    fin = s2 + 14;
`endif

    next_slot_to(fin);
    g = 0;
    while (q.size() > 0 && g < 200) begin
      @(posedge clk);
      g++;
    end
    chk("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
